// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enable-loaded register between NUM_REQ
// requesters over a 4-phase req/ack handshake; all outputs are registered.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       reg_en,
  output logic [WIDTH-1:0]           reg_d,
  output logic [IDX_W-1:0]           grant_id,
  output logic                       busy,
  output logic [15:0]                wr_count
);

  localparam int PAD = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               reg_en_q;
  logic [WIDTH-1:0]   reg_d_q;
  logic [IDX_W-1:0]   grant_q;
  logic               busy_q;
  logic [15:0]        wr_count_q;

  logic [PAD-1:0]     req_pad;
  logic [WIDTH-1:0]   data_arr [PAD];
  logic               found_d;
  logic [IDX_W-1:0]   win_idx_d;
  logic [NUM_REQ-1:0] win_oh_d;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W:0]     sum_d;

  // Indices at or above NUM_REQ see a zero request and zero data, so they
  // can never win.
  genvar gi;
  generate
    for (gi = 0; gi < PAD; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_live
        assign req_pad[gi]  = req[gi];
        assign data_arr[gi] = data_in[gi*WIDTH +: WIDTH];
      end else begin : g_dead
        assign req_pad[gi]  = 1'b0;
        assign data_arr[gi] = '0;
      end
    end
  endgenerate

  // Walk downward so the lowest offset from the pointer is the last to
  // assign and therefore wins.
  always_comb begin
    found_d   = 1'b0;
    win_idx_d = '0;
    sum_d     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_d = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum_d >= (IDX_W+1)'(NUM_REQ)) begin
        sum_d = sum_d - (IDX_W+1)'(NUM_REQ);
      end
      if (req_pad[sum_d[IDX_W-1:0]]) begin
        found_d   = 1'b1;
        win_idx_d = sum_d[IDX_W-1:0];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_oh_d[gi] = found_d && (win_idx_d == IDX_W'(gi));
    end
  endgenerate

  assign ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      ack_q      <= '0;
      reg_en_q   <= 1'b0;
      reg_d_q    <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      wr_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found_d) begin
            reg_d_q  <= data_arr[win_idx_d];
            grant_q  <= win_idx_d;
            reg_en_q <= 1'b1;
            ack_q    <= win_oh_d;
            busy_q   <= 1'b1;
            state_q  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          reg_en_q <= 1'b0;
          ack_q    <= '0;
          if (wr_count_q != 16'hFFFF) begin
            wr_count_q <= wr_count_q + 16'd1;
          end
          state_q  <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // The winner holding its request stalls everyone else by design.
          if (!req_pad[grant_q]) begin
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          reg_en_q <= 1'b0;
          ack_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign reg_en   = reg_en_q;
  assign reg_d    = reg_d_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for held requests, late data changes and async reset.
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic        reg_en;
  logic [7:0]  reg_d;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;

  int n_chk;
  int n_fail;

  reg_write_arbiter #(
    .NUM_REQ(4),
    .WIDTH  (8),
    .IDX_W  (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .data_in (data_in),
    .ack     (ack),
    .reg_en  (reg_en),
    .reg_d   (reg_d),
    .grant_id(grant_id),
    .busy    (busy),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        en;
    logic [7:0]  rd;
    logic [1:0]  gid;
    logic        busy;
    logic [15:0] wr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] q, input logic [31:0] d,
                              input logic [3:0] a, input logic e, input logic [7:0] rd,
                              input logic [1:0] g, input logic b, input logic [15:0] w);
    vec_t v;
    v.rst_n = r; v.req = q; v.data = d; v.ack = a; v.en = e;
    v.rd = rd; v.gid = g; v.busy = b; v.wr = w;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [3:0] a, input logic e,
                         input logic [7:0] rd, input logic [1:0] g, input logic b,
                         input logic [15:0] w);
    chk("ack", idx, 32'(ack), 32'(a));
    chk("reg_en", idx, 32'(reg_en), 32'(e));
    chk("reg_d", idx, 32'(reg_d), 32'(rd));
    chk("grant_id", idx, 32'(grant_id), 32'(g));
    chk("busy", idx, 32'(busy), 32'(b));
    chk("wr_count", idx, 32'(wr_count), 32'(w));
    $display("step %0d: req=%b ack=%b en=%b reg_d=%h gid=%0d busy=%b wr=%0d",
             idx, req, ack, reg_en, reg_d, grant_id, busy, wr_count);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] S1 = 32'h0000_A500;
  localparam logic [31:0] D  = 32'h4332_2110;

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    req     = '0;
    data_in = '0;

    // rst_n, req, data, ack, en, reg_d, gid, busy, wr
    add(0, 4'b0000, 0,  4'b0000, 0, 8'h00, 0, 0, 0);
    add(1, 4'b0000, S1, 4'b0000, 0, 8'h00, 0, 0, 0);
    add(1, 4'b0010, S1, 4'b0010, 1, 8'hA5, 1, 1, 0);
    add(1, 4'b0010, S1, 4'b0000, 0, 8'hA5, 1, 1, 1);
    add(1, 4'b0010, S1, 4'b0000, 0, 8'hA5, 1, 1, 1);
    add(1, 4'b0000, S1, 4'b0000, 0, 8'hA5, 1, 0, 1);
    add(1, 4'b0000, S1, 4'b0000, 0, 8'hA5, 1, 0, 1);
    add(0, 4'b1111, D,  4'b0000, 0, 8'h00, 0, 0, 0);
    add(1, 4'b1111, D,  4'b0001, 1, 8'h10, 0, 1, 0);
    add(1, 4'b1111, D,  4'b0000, 0, 8'h10, 0, 1, 1);
    add(1, 4'b1110, D,  4'b0000, 0, 8'h10, 0, 0, 1);
    add(1, 4'b1111, D,  4'b0010, 1, 8'h21, 1, 1, 1);
    add(1, 4'b1111, D,  4'b0000, 0, 8'h21, 1, 1, 2);
    add(1, 4'b1101, D,  4'b0000, 0, 8'h21, 1, 0, 2);
    add(1, 4'b1111, D,  4'b0100, 1, 8'h32, 2, 1, 2);
    add(1, 4'b1111, D,  4'b0000, 0, 8'h32, 2, 1, 3);
    add(1, 4'b1011, D,  4'b0000, 0, 8'h32, 2, 0, 3);
    add(1, 4'b1111, D,  4'b1000, 1, 8'h43, 3, 1, 3);
    add(1, 4'b1111, D,  4'b0000, 0, 8'h43, 3, 1, 4);
    add(1, 4'b0111, D,  4'b0000, 0, 8'h43, 3, 0, 4);
    add(1, 4'b1111, D,  4'b0001, 1, 8'h10, 0, 1, 4);
    add(1, 4'b1111, D,  4'b0000, 0, 8'h10, 0, 1, 5);
    add(1, 4'b1110, D,  4'b0000, 0, 8'h10, 0, 0, 5);
    add(1, 4'b0100, D,  4'b0100, 1, 8'h32, 2, 1, 5);
    add(1, 4'b0100, D,  4'b0000, 0, 8'h32, 2, 1, 6);
    add(1, 4'b0000, D,  4'b0000, 0, 8'h32, 2, 0, 6);
    add(1, 4'b1001, D,  4'b1000, 1, 8'h43, 3, 1, 6);
    add(1, 4'b1001, D,  4'b0000, 0, 8'h43, 3, 1, 7);
    add(1, 4'b0001, D,  4'b0000, 0, 8'h43, 3, 0, 7);
    add(1, 4'b1001, D,  4'b0001, 1, 8'h10, 0, 1, 7);
    add(1, 4'b1001, D,  4'b0000, 0, 8'h10, 0, 1, 8);
    add(1, 4'b1000, D,  4'b0000, 0, 8'h10, 0, 0, 8);
    add(1, 4'b0000, D,  4'b0000, 0, 8'h10, 0, 0, 8);

    for (int i = 0; i < vecs.size(); i++) begin
      reset_n = vecs[i].rst_n;
      req     = vecs[i].req;
      data_in = vecs[i].data;
      step();
      chk_all(i, vecs[i].ack, vecs[i].en, vecs[i].rd, vecs[i].gid,
              vecs[i].busy, vecs[i].wr);
    end

    // Held request: pointer is 1, winner 1 keeps req high while others wait.
    req = 4'b1111;
    step();
    chk_all(100, 4'b0010, 1, 8'h21, 1, 1, 8);
    step();
    chk_all(101, 4'b0000, 0, 8'h21, 1, 1, 9);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all(102 + i, 4'b0000, 0, 8'h21, 1, 1, 9);
    end
    req = 4'b1101;
    step();
    chk_all(112, 4'b0000, 0, 8'h21, 1, 0, 9);
    step();
    chk_all(113, 4'b0100, 1, 8'h32, 2, 1, 9);
    step();
    chk_all(114, 4'b0000, 0, 8'h32, 2, 1, 10);
    req = 4'b0000;
    step();
    chk_all(115, 4'b0000, 0, 8'h32, 2, 0, 10);

    // Data change after grant: pointer is 3, requester 0 wins by wrap.
    data_in = 32'h4332_2155;
    req     = 4'b0001;
    step();
    chk_all(200, 4'b0001, 1, 8'h55, 0, 1, 10);
    data_in = 32'h4332_21AA;
    step();
    chk_all(201, 4'b0000, 0, 8'h55, 0, 1, 11);
    req = 4'b0000;
    step();
    chk_all(202, 4'b0000, 0, 8'h55, 0, 0, 11);
    step();
    chk_all(203, 4'b0000, 0, 8'h55, 0, 0, 11);

    // Async reset during WRITE: pointer is 1 before reset, 0 after.
    data_in = D;
    req     = 4'b0100;
    step();
    chk_all(300, 4'b0100, 1, 8'h32, 2, 1, 11);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all(301, 4'b0000, 0, 8'h00, 0, 0, 0);
    step();
    chk_all(302, 4'b0000, 0, 8'h00, 0, 0, 0);
    reset_n = 1'b1;
    req     = 4'b1111;
    step();
    chk_all(303, 4'b0001, 1, 8'h10, 0, 1, 0);
    step();
    chk_all(304, 4'b0000, 0, 8'h10, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
